serial_nibble_adder: RTL and testbench
======================================

// Module: serial_nibble_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder built around the team's 4-bit ripple adder slice.
//  Latches two operands, issues one nibble per cycle (LSB first) to the external
//  4-bit adder (add_a/add_b/add_cin) and consumes its result (add_sum/add_cout),
//  then chains the carry into the next nibble. It is the sequencing stage that
//  feeds the 4-bit adder and assembles its outputs into a full-width result.
// PARAMETERS
//  WIDTH   16   operand/result width; multiple of 4, >= 8
//  N       WIDTH/4 (localparam) number of nibble steps
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  rst      in   1      synchronous reset, active-high
//  start    in   1      request; sampled only in IDLE
//  op_a     in   WIDTH  operand A, captured when start accepted
//  op_b     in   WIDTH  operand B, captured when start accepted
//  cin      in   1      carry-in, captured when start accepted
//  busy     out  1      high while in RUN
//  done     out  1      one-cycle pulse, result valid
//  sum      out  WIDTH  result, held from done until next accepted start
//  cout     out  1      final carry, held like sum
//  add_a    out  4      nibble of A to 4-bit adder
//  add_b    out  4      nibble of B to 4-bit adder
//  add_cin  out  1      carry to 4-bit adder
//  add_sum  in   4      sum from 4-bit adder (combinational, same cycle)
//  add_cout in   1      carry from 4-bit adder (combinational, same cycle)
// BEHAVIOUR
//  - Clocking: single clk; rst synchronous active-high (decided).
//  - Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, add_a=0, add_b=0,
//    add_cin=0; internal idx=0, carry=0. rst in any state (incl. mid-RUN)
//    aborts: partial result discarded, all outputs zero next cycle.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: start=1 at edge => latch op_a, op_b, cin->carry, idx=0, go RUN.
//    RUN : add_a=A[4*idx+:4], add_b=B[4*idx+:4], add_cin=carry (regs, not ports).
//          Each edge: sum[4*idx+:4]<=add_sum, carry<=add_cout, idx<=idx+1.
//          After step idx=N-1: cout<=add_cout, go DONE.
//    DONE: done=1 for exactly one cycle, then IDLE.
//  - Latency: start sampled at edge k -> busy high cycles k+1..k+N, done high
//    cycle k+N+1; next start accepted at edge k+N+2 earliest.
//  - start while RUN or DONE is ignored (not queued); op_a/op_b/cin changes
//    after acceptance have no effect.
//  - add_a/add_b/add_cin = 0 outside RUN. sum bits of not-yet-processed
//    nibbles are undefined during RUN; only sum/cout at/after done are valid.
//  - Arithmetic: {cout,sum} == op_a + op_b + cin (WIDTH+1 bits, no truncation);
//    carry wraps through all N nibbles (e.g. FFFF+1 ripples 4 steps).
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined: adds port sub (in,1), captured with start.
//    sub=1: B latched as ~op_b, carry latched as 1 (cin ignored);
//    result = op_a - op_b mod 2^WIDTH, cout=1 means no borrow.
//    sub=0: identical to add behaviour.
//  Undefined: no sub port; add only.
// TESTING (WIDTH=16)
//  - 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0; busy 4 cycles, done cycle 5.
//  - 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry through every nibble).
//  - 0x0000+0xFFFF, cin=1 -> sum=0x0000, cout=1; 0x7FFF+0x7FFF -> 0xFFFE, 0.
//  - start pulsed again during RUN with other operands -> ignored; first result
//    delivered unchanged, single done pulse.
//  - rst asserted at 2nd RUN cycle -> next cycle IDLE, all outputs 0; new start
//    0x0001+0x0001 -> 0x0002.
//  - SERIAL_ADDER_SUB_EN, sub=1: 0x1000-0x0001 -> 0x0FFF, cout=1;
//    0x0000-0x0001 -> 0xFFFF, cout=0.

Source files
------------

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder that sequences nibbles through an external 4-bit adder slice.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds port i_sub).
module serial_nibble_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic [3:0]       o_add_a,
   output logic [3:0]       o_add_b,
   output logic             o_add_cin,
   input  logic [3:0]       i_add_sum,
   input  logic             i_add_cout
);
   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic [IW-1:0]    r_idx;
   logic             r_carry, r_cout;
   logic [WIDTH-1:0] w_b_load;
   logic             w_carry_load;
   logic             w_accept, w_run, w_last;
   logic [IW+1:0]    w_base;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is A + ~B + 1; the latched carry replaces cin.
   assign w_b_load     = i_sub ? ~i_op_b : i_op_b;
   assign w_carry_load = i_sub | i_cin;
`else
   assign w_b_load     = i_op_b;
   assign w_carry_load = i_cin;
`endif

   assign w_run    = (r_state == StRun);
   assign w_accept = (r_state == StIdle) && i_start;
   assign w_last   = (r_idx == LastIdx);
   assign w_base   = {r_idx, 2'b00};

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_d = StRun;
         StRun:   if (w_last) w_state_d = StDone;
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= i_op_a;
         r_b     <= w_b_load;
         r_carry <= w_carry_load;
         r_idx   <= '0;
      end else if (w_run) begin
         r_sum[w_base +: 4] <= i_add_sum;
         r_carry            <= i_add_cout;
         r_idx              <= w_last ? '0 : r_idx + 1'b1;
         if (w_last) begin
            r_cout <= i_add_cout;
         end
      end
   end

   always_comb begin
      o_add_a   = 4'h0;
      o_add_b   = 4'h0;
      o_add_cin = 1'b0;
      if (w_run) begin
         o_add_a   = r_a[w_base +: 4];
         o_add_b   = r_b[w_base +: 4];
         o_add_cin = r_carry;
      end
   end

   assign o_busy = w_run;
   assign o_done = (r_state == StDone);
   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Self-checking bench for serial_nibble_adder (WIDTH=16) with a behavioural timeline/sum model.
// Subtract tests are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_nibble_adder;
   localparam int unsigned WIDTH = 16;
   localparam int N = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst, start, cin, sub;
   logic [WIDTH-1:0] op_a, op_b;
   logic             busy, done, cout, add_cin, add_cout;
   logic [WIDTH-1:0] sum;
   logic [3:0]       add_a, add_b, add_sum;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   // Reference 4-bit slice, combinational.
   assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   serial_nibble_adder #(.WIDTH(WIDTH)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_op_a     (op_a),
      .i_op_b     (op_b),
      .i_cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .i_sub      (sub),
`endif
      .o_busy     (busy),
      .o_done     (done),
      .o_sum      (sum),
      .o_cout     (cout),
      .o_add_a    (add_a),
      .o_add_b    (add_b),
      .o_add_cin  (add_cin),
      .i_add_sum  (add_sum),
      .i_add_cout (add_cout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: transaction timeline by edge number plus arithmetic result.
   logic             m_init = 1'b0;
   logic             m_have = 1'b0;
   int               m_acc = 0;
   int               m_free = 0;
   logic [WIDTH-1:0] m_a = '0, m_b = '0;
   logic             m_c = 1'b0;
   logic [WIDTH:0]   m_res = '0, m_held = '0;

`ifdef SERIAL_ADDER_SUB_EN
   wire m_sub = sub;
`else
   wire m_sub = 1'b0;
`endif

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_init <= 1'b1;
         m_have <= 1'b0;
         m_held <= '0;
         m_free <= cyc + 1;
      end else if (m_init) begin
         if (m_have && cyc == m_acc + N) m_held <= m_res;
         if (start && cyc >= m_free) begin
            m_have <= 1'b1;
            m_acc  <= cyc;
            m_free <= cyc + N + 2;
            m_a    <= op_a;
            m_b    <= m_sub ? ~op_b : op_b;
            m_c    <= m_sub ? 1'b1 : cin;
            m_res  <= {1'b0, op_a} + {1'b0, (m_sub ? ~op_b : op_b)} + (WIDTH+1)'(m_sub | cin);
         end
      end
   end

   int          c_e, c_i;
   logic        c_busy, c_done, c_cin;
   logic [31:0] c_mask;

   always @(negedge clk) begin
      if (m_init) begin
         c_e    = cyc - 1;
         c_busy = m_have && c_e >= m_acc && c_e <= m_acc + N - 1;
         c_done = m_have && c_e == m_acc + N;
         chk("busy", 32'(busy), 32'(c_busy));
         chk("done", 32'(done), 32'(c_done));
         if (!c_busy) begin
            chk("sum", 32'(sum), 32'(m_held[WIDTH-1:0]));
            chk("cout", 32'(cout), 32'(m_held[WIDTH]));
            chk("add_a_idle", 32'(add_a), 32'h0);
            chk("add_b_idle", 32'(add_b), 32'h0);
            chk("add_cin_idle", 32'(add_cin), 32'h0);
         end else begin
            c_i    = c_e - m_acc;
            c_mask = (32'd1 << (4 * c_i)) - 32'd1;
            c_cin  = 1'(((32'(m_a) & c_mask) + (32'(m_b) & c_mask) + 32'(m_c)) >> (4 * c_i));
            chk("add_a", 32'(add_a), (32'(m_a) >> (4 * c_i)) & 32'hF);
            chk("add_b", 32'(add_b), (32'(m_b) >> (4 * c_i)) & 32'hF);
            chk("add_cin", 32'(add_cin), 32'(c_cin));
         end
      end
   end

   // One transaction with literal expectations; poke=1 re-pulses start mid-RUN.
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s, input logic [15:0] exp_sum, input logic exp_cout,
                          input bit poke, input string name);
      int n_busy = 0, n_done = 0, done_at = -1;
      logic [15:0] got_sum = '0;
      logic        got_cout = 1'b0;
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         start = 1'b0;
         op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         if (poke && k == 1) start = 1'b1;
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            done_at  = k;
            got_sum  = sum;
            got_cout = cout;
         end
      end
      sub = 1'b0;
      chk({name, "_sum"}, 32'(got_sum), 32'(exp_sum));
      chk({name, "_cout"}, 32'(got_cout), 32'(exp_cout));
      chk({name, "_busy_cycles"}, 32'(n_busy), 32'd4);
      chk({name, "_done_pulses"}, 32'(n_done), 32'd1);
      chk({name, "_done_cycle"}, 32'(done_at), 32'd4);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_sum", 32'(sum), 32'h0);
      chk("rst_cout", 32'(cout), 32'h0);
      chk("rst_add", {23'b0, add_cin, add_b, add_a}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run_txn(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "t1234");
      run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "tffff");
      run_txn(16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "tcin");
      run_txn(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, "t7fff");
      run_txn(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'hB4B4, 1'b0, 1'b1, "tpoke");

      // Abort on the second RUN cycle.
      @(negedge clk);
      start = 1'b1; op_a = 16'h9999; op_b = 16'h8888; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_sum", 32'(sum), 32'h0);
      chk("abort_cout", 32'(cout), 32'h0);
      chk("abort_add", {23'b0, add_cin, add_b, add_a}, 32'h0);
      run_txn(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "tafter");

`ifdef SERIAL_ADDER_SUB_EN
      run_txn(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, "tsub1");
      run_txn(16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "tsub2");
`endif

      // Random traffic: starts at any time, occasional resets, edge-heavy operands.
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 80) == 0);
         start = ($urandom_range(0, 2) == 0);
         op_a  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
         op_b  = ($urandom_range(0, 5) == 0) ? 16'h0001 : 16'($urandom);
         cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         sub   = 1'($urandom);
`endif
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0; sub = 1'b0;
      repeat (N + 4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
